wb_master_single: RTL and testbench

//  Wishbone classic-cycle bus master that sits directly upstream of wb_slave_register.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_cycle_timer.sv | 32 +++
 rtl/wb_master_single.sv | 130 +++++++++++++
 tb/tb_wb_master_single.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone classic single-cycle master.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_mst_state_t;

  localparam logic OP_CLASSIC_SINGLE_READ  = 1'b0;
  localparam logic OP_CLASSIC_SINGLE_WRITE = 1'b1;

  // Bit width of a counter that must reach cycles-1 (at least one bit).
  function automatic int timer_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/wb_cycle_timer.sv
// Counts enabled cycles since the last clear and flags the last allowed cycle.
module wb_cycle_timer
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = timer_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_reg;

  // No saturation: the owner leaves the counting state on the expired cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/wb_master_single.sv
// Wishbone classic single READ/WRITE master with valid/ready request and response ports.
module wb_master_single
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i
);

  wb_mst_state_t         state_reg, state_next;
  logic                  cyc_reg, cyc_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] adr_reg, adr_next;
  logic [DATA_WIDTH-1:0] dat_reg, dat_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic                  timer_expired;

  // Timer runs only while waiting for ack; ack on the expiry edge takes priority below.
  wb_cycle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (state_reg != BUS),
    .enable ((state_reg == BUS) && !ack_i),
    .expired(timer_expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= IDLE;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cyc_reg       <= cyc_next;
      we_reg        <= we_next;
      adr_reg       <= adr_next;
      dat_reg       <= dat_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cyc_next       = cyc_reg;
    we_next        = we_reg;
    adr_next       = adr_reg;
    dat_next       = dat_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_err_next   = rsp_err_reg;
    rsp_rdata_next = rsp_rdata_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          adr_next   = req_addr_i;
          dat_next   = req_wdata_i;
          we_next    = req_we_i;
          cyc_next   = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        if (ack_i) begin
          cyc_next       = 1'b0;
          we_next        = 1'b0;
          rsp_rdata_next = (we_reg == OP_CLASSIC_SINGLE_WRITE) ? '0 : dat_i;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else if (timer_expired) begin
          cyc_next       = 1'b0;
          we_next        = 1'b0;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_next = 1'b0;
          rsp_err_next   = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Gated by reset so that every output reads 0 while reset is held.
  assign req_ready_o = rst_i && (state_reg == IDLE);
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign cyc_o       = cyc_reg;
  assign stb_o       = cyc_reg;
  assign we_o        = we_reg;
  assign adr_o       = adr_reg;
  assign dat_o       = dat_reg;

endmodule

// File: tb/tb_wb_master_single.sv
// Self-checking bench: wb_master_single against a behavioural register slave and reference model.
module tb_wb_master_single;
  import wb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          cyc, stb, we, ack;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o, dat_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_master_single #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack)
  );

  // Register-file slave: acks after ack_delay wait cycles of an active cycle.
  logic [DW-1:0] slv_mem [16];
  int   ack_delay = 0;
  int   slv_cnt = 0;
  logic ack_force = 1'b0;
  logic mem_clr = 1'b1;

  always @(posedge clk) begin
    if (cyc && !ack) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
    end else if (cyc && stb && we && ack) begin
      slv_mem[adr[3:0]] <= dat_o;
    end
  end

  assign ack   = ack_force | (cyc && (slv_cnt >= ack_delay));
  assign dat_i = slv_mem[adr[3:0]];

  logic [DW-1:0] ref_mem [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete request/response. hold<0 keeps rsp_ready high throughout;
  // queue_next presents a read of the same address while the response is pending.
  task automatic run_txn(input logic t_we, input logic [3:0] t_addr, input logic [31:0] t_wdata,
                         input int t_delay, input int t_hold, input bit queue_next);
    int            exp_cycles;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            n;
    if (t_delay <= TO - 1) begin
      exp_cycles = t_delay + 1;
      exp_err    = 1'b0;
      exp_rdata  = t_we ? '0 : ref_mem[t_addr];
      if (t_we) ref_mem[t_addr] = t_wdata;
    end else begin
      exp_cycles = TO;
      exp_err    = 1'b1;
      exp_rdata  = '0;
    end
    ack_delay = t_delay;
    req_valid = 1'b1;
    req_we    = t_we;
    req_addr  = {28'h0, t_addr};
    req_wdata = t_wdata;
    rsp_ready = (t_hold < 0);
    #1;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("cyc_start", {cyc, stb, we}, {2'b11, t_we});
    check("adr", adr, {28'h0, t_addr});
    check("dat_o", dat_o, t_wdata);
    n = 0;
    while (cyc && n < 200) begin
      if (adr !== {28'h0, t_addr} || we !== t_we) check("bus_stable", {we, adr}, {t_we, 28'h0, t_addr});
      n++;
      @(negedge clk);
    end
    check("cyc_cycles", n, exp_cycles);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("bus_idle", {cyc, stb, we}, 3'b000);
    check("dat_o_held", dat_o, t_wdata);
    $display("txn we=%0d addr=%0h wdata=%08h delay=%0d -> cycles=%0d err=%0d rdata=%08h",
             t_we, t_addr, t_wdata, t_delay, n, rsp_err, rsp_rdata);
    for (int i = 0; i < t_hold; i++) begin
      if (queue_next) begin
        req_valid = 1'b1;
        req_we    = OP_CLASSIC_SINGLE_READ;
        req_addr  = {28'h0, t_addr};
      end
      #1;
      check("hold_ready", req_ready, 0);
      check("hold_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, exp_err, exp_rdata});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("rsp_done", {rsp_valid, rsp_err, req_ready, cyc}, 4'b0010);
  endtask

  int dly_tab [8] = '{0, 1, 3, 5, 14, 15, 16, 40};

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {req_ready, rsp_valid, rsp_err, cyc, stb, we}, 6'b0);
    check("reset_adr_dat", {adr, dat_o, rsp_rdata}, 96'h0);
    rst = 1'b1;
    mem_clr = 1'b0;
    #1;
    check("ready_after_reset", req_ready, 1);

    // Asynchronous reset in the middle of a bus cycle.
    @(negedge clk);
    ack_delay = 1000;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("cyc_before_rst", cyc, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_drop", {cyc, stb, rsp_valid}, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_after_mid_rst", req_ready, 1);
    @(negedge clk);

    run_txn(1'b1, 4'h0, 32'hDEADBEEF, 0, 1, 1'b0);
    run_txn(1'b0, 4'h0, 32'h0, 0, 1, 1'b0);
    check("readback_deadbeef", ref_mem[0], 32'hDEADBEEF);
    run_txn(1'b0, 4'h5, 32'h0, 1000, 0, 1'b0);
    run_txn(1'b1, 4'h6, 32'h12345678, 1000, 0, 1'b0);
    run_txn(1'b0, 4'h6, 32'h0, 2, -1, 1'b0);
    run_txn(1'b1, 4'h9, 32'hA5A5_0F0F, 15, 0, 1'b0);
    run_txn(1'b0, 4'h9, 32'h0, 15, 0, 1'b0);
    run_txn(1'b0, 4'h9, 32'h0, 16, 0, 1'b0);

    // Queued request while the response is held off.
    run_txn(1'b1, 4'h7, 32'hCAFE_F00D, 2, 5, 1'b1);
    run_txn(1'b0, 4'h7, 32'h0, 0, 0, 1'b0);

    // ack outside a bus cycle is ignored.
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    check("ack_idle_ignored", {cyc, rsp_valid, req_ready}, 3'b001);
    ack_force = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
              dly_tab[$urandom_range(0, 7)], $urandom_range(0, 3) - 1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
